// File: rtl/if_fetch_queue_pkg.sv
// Shared types and constants for the if_fetch_queue instruction-fetch stage.
package if_fetch_queue_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned EXC_W = 5;

    localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;

    localparam logic [XLEN-1:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [XLEN-1:0] DEF_HANDLER_PC = 32'h0000_4180;

    typedef enum logic [0:0] {
        ST_FETCH        = 1'b0,
        ST_SLOT_PENDING = 1'b1
    } fetch_state_e;

    // One queued fetch: 32 + 32 + 5 = 69 bits
    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  instr;
        logic [EXC_W-1:0] exccode;
    } fq_entry_t;

    // Misaligned or outside the legal instruction window
    function automatic logic fetch_addr_bad(input logic [XLEN-1:0] pc,
                                            input logic [XLEN-1:0] lo,
                                            input logic [XLEN-1:0] hi);
        return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
    endfunction

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// DEPTH-entry ring buffer of fetch entries with push/pop and two flush flavours.
module if_fetch_queue_fifo
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      reset_i,
    input  logic      push_i,
    input  fq_entry_t push_data_i,
    input  logic      pop_i,
    input  logic      flush_all_i,
    input  logic      flush_keep_head_i,
    output fq_entry_t head_o,
    output logic      empty_o,
    output logic      full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Flushes win over push/pop; keep-head assumes a non-empty queue
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_all_i) begin
            wr_ptr_d = rd_ptr_q;
            count_d  = '0;
        end else if (flush_keep_head_i) begin
            wr_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = CNT_W'(1);
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data-only; validity lives in count_q
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_all_i && !flush_keep_head_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/if_fetch_queue.sv
// Queued instruction-fetch stage: PC, delay-slot-aware redirect, interrupt flush, AdEL tagging.
// Define IF_FETCH_BYPASS_EN to forward the current fetch straight to ID when the queue is empty.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH      = 4,
    parameter logic [XLEN-1:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [XLEN-1:0] HANDLER_PC = DEF_HANDLER_PC,
    parameter logic [XLEN-1:0] ADDR_LO    = 32'h0000_3000,
    parameter logic [XLEN-1:0] ADDR_HI    = 32'h0000_6ffc
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             req_i,
    input  logic             redirect_valid_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    input  logic             id_branch_i,
    output logic [XLEN-1:0]  im_addr_o,
    input  logic [XLEN-1:0]  im_rdata_i,
    output logic             deq_valid_o,
    input  logic             deq_ready_i,
    output logic [XLEN-1:0]  deq_pc_o,
    output logic [XLEN-1:0]  deq_instr_o,
    output logic [EXC_W-1:0] deq_exccode_o,
    output logic             deq_bd_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] target_q, target_d;

    fq_entry_t fetch_entry, head;
    logic      fifo_empty, fifo_full;
    logic      push, pop, flush_all, flush_keep_head;
    logic      bypass_act, deq_fire;

    // Tag the word at the current PC; a faulting fetch never exposes memory data
    always_comb begin
        fetch_entry.pc = pc_q;
        if (fetch_addr_bad(pc_q, ADDR_LO, ADDR_HI)) begin
            fetch_entry.instr   = '0;
            fetch_entry.exccode = EXC_ADEL;
        end else begin
            fetch_entry.instr   = im_rdata_i;
            fetch_entry.exccode = EXC_NONE;
        end
    end

`ifdef IF_FETCH_BYPASS_EN
    assign bypass_act = fifo_empty && (state_q == ST_FETCH) && !req_i && !redirect_valid_i;
`else
    assign bypass_act = 1'b0;
`endif

    always_comb begin
        deq_valid_o   = 1'b0;
        deq_pc_o      = '0;
        deq_instr_o   = '0;
        deq_exccode_o = '0;
        if (bypass_act) begin
            deq_valid_o   = 1'b1;
            deq_pc_o      = fetch_entry.pc;
            deq_instr_o   = fetch_entry.instr;
            deq_exccode_o = fetch_entry.exccode;
        end else if (!fifo_empty) begin
            deq_valid_o   = 1'b1;
            deq_pc_o      = head.pc;
            deq_instr_o   = head.instr;
            deq_exccode_o = head.exccode;
        end
    end

    assign deq_bd_o  = deq_valid_o & id_branch_i;
    assign deq_fire  = deq_valid_o & deq_ready_i;
    assign im_addr_o = pc_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (req_i) begin
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH:        if (redirect_valid_i && fifo_empty) state_d = ST_SLOT_PENDING;
                ST_SLOT_PENDING: state_d = ST_FETCH;
                default:         state_d = ST_FETCH;
            endcase
        end
    end

    // With an empty queue the current PC is the delay slot, so it is held and the target parked
    always_comb begin
        pc_d            = pc_q;
        target_d        = target_q;
        push            = 1'b0;
        pop             = 1'b0;
        flush_all       = 1'b0;
        flush_keep_head = 1'b0;
        if (req_i) begin
            flush_all = 1'b1;
            pc_d      = HANDLER_PC;
        end else begin
            pop = deq_fire && !bypass_act;
            case (state_q)
                ST_FETCH: begin
                    if (redirect_valid_i) begin
                        if (fifo_empty) begin
                            target_d = redirect_pc_i;
                        end else begin
                            pc_d            = redirect_pc_i;
                            flush_all       = deq_fire;
                            flush_keep_head = !deq_fire;
                        end
                    end else if (!fifo_full || deq_fire) begin
                        push = !(bypass_act && deq_ready_i);
                        pc_d = pc_q + 32'd4;
                    end
                end
                ST_SLOT_PENDING: begin
                    push = 1'b1;
                    pc_d = target_q;
                end
                default: ;
            endcase
        end
    end

    if_fetch_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .push_i            (push),
        .push_data_i       (fetch_entry),
        .pop_i             (pop),
        .flush_all_i       (flush_all),
        .flush_keep_head_i (flush_keep_head),
        .head_o            (head),
        .empty_o           (fifo_empty),
        .full_o            (fifo_full)
    );

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage for the pipelined MIPS core: owns the PC, fetches one word per cycle from instruction memory into a DEPTH-entry queue, and presents instructions to ID with a valid/ready handshake. It adds decoupling and stall absorption, branch redirect with delay-slot preservation, interrupt redirect, and per-entry AdEL fetch-exception tagging. It sits between the IM port and the ID stage, replacing the single-register IF stage.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2
- RESET_PC, 32'h3000: PC after reset
- HANDLER_PC, 32'h4180: PC loaded on req
- ADDR_LO, 32'h3000: lowest legal fetch address
- ADDR_HI, 32'h6ffc: highest legal fetch address
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req  in  1  interrupt/exception request; flush and go to HANDLER_PC
- redirect_valid  in  1  branch/jump in ID taken this cycle
- redirect_pc  in  32  branch/jump target
- id_branch  in  1  ID currently holds a branch/jump (delay-slot marker)
- im_addr  out  32  instruction-memory address (current PC)
- im_rdata  in  32  instruction word for im_addr, same cycle
- deq_valid  out  1  head entry available to ID
- deq_ready  in  1  ID accepts head this cycle
- deq_pc  out  32  PC of head entry
- deq_instr  out  32  instruction of head; 0 when deq_exccode≠0
- deq_exccode  out  5  `AdEL` or 0
- deq_bd  out  1  deq_valid & id_branch

## Operation
- Enqueue fire: state FETCH and (count<DEPTH or deq fire). Entry = {pc, instr, exccode}; then pc ← pc+4.
- Exception tag: pc[1:0]≠0 or pc<ADDR_LO or pc>ADDR_HI → exccode=`AdEL`, instr stored as 0. PC still advances; no other side effects.
- Dequeue fire: deq_valid & deq_ready; head pops.
- Simultaneous enqueue and dequeue when full: permitted; count unchanged.
- redirect_valid (ID holds branch; queue head is its delay slot):
  - head present and not dequeued this cycle: keep only the head, flush the rest.
  - head dequeued this cycle: flush the whole queue.
  - queue empty: enter SLOT_PENDING.
  - FETCH state: pc ← redirect_pc; no enqueue from the old stream that cycle.
- SLOT_PENDING: enqueue one word at the current pc (the slot), then pc ← saved redirect_pc and return to FETCH. The target is held in a register.
- req: flush everything, including a pending slot; pc ← HANDLER_PC; state ← FETCH. req has priority over redirect_valid and over enqueue in the same cycle.
- redirect_valid in SLOT_PENDING is illegal. The bench asserts against it.

## Timing
- Reset: pc=RESET_PC, state=FETCH, count=0, deq_valid=0, deq_pc=0, deq_instr=0, deq_exccode=0, deq_bd=0.
- Reset mid-operation discards all entries and any pending slot.
- Latency without bypass: a word fetched in cycle N is visible on deq_* in cycle N+1.
- Redirect in cycle N: fetch of redirect_pc occurs in cycle N+1. In the SLOT_PENDING case it occurs in cycle N+2.
- req in cycle N: im_addr=HANDLER_PC in cycle N+1; deq_valid=0 in N+1 (bypass: see below).
- Count is $clog2(DEPTH+1) bits. Pointers are $clog2(DEPTH) bits and wrap naturally. pc+4 wraps modulo 2^32.

## Configuration
- IF_FETCH_BYPASS_EN defined: when the queue is empty, state=FETCH and no req/redirect is active, the current im_rdata/pc/exccode drive deq_* combinationally with deq_valid=1. If deq_ready, the word is consumed without being written.
- IF_FETCH_BYPASS_EN undefined: deq_* come only from queue storage; minimum latency is one cycle.

## Structure
- Shared constants (`constants.v`): `AdEL`=5'd4, default RESET_PC/HANDLER_PC values, ExcCode width.
- Sub-module if_fifo: a DEPTH×69-bit ring buffer with push, pop, count, and a flush_keep_head/flush_all pair. The top level holds the PC, the FETCH/SLOT_PENDING state machine, the exception check and the bypass mux.

## Test plan
- Reset, deq_ready=1, legal code at 0x3000: deq_pc sequence 0x3000, 0x3004, 0x3008…; first deq_valid at cycle 1 without bypass, cycle 0 with bypass.
- deq_ready=0 for 10 cycles: count saturates at DEPTH; im_addr holds 0x3000+4·DEPTH; no entry lost or duplicated after release.
- Branch dequeued at 0x3000, slot 0x3004 queued, redirect_valid to 0x3100 while deq_ready=0: queue holds only 0x3004 with deq_bd=1; the next entry is 0x3100.
- Redirect with an empty queue: SLOT_PENDING fetches 0x3004, then 0x3100; exactly one slot entry appears.
- Redirect from 0x6ffc stream to 0x3002: entry pc 0x3002 carries exccode=4 and instr=0. Sequential fetch from 0x6ffc gives 0x7000 with exccode=4.
- req and redirect_valid together with a full queue: all entries flushed; im_addr=0x4180 next cycle; redirect ignored.
